// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results with in-order load returns onto the
// register file's single write port and exports a per-register busy scoreboard.
module wb_arbiter #(
  parameter int unsigned RADDRWIDTH = 3,
  parameter int unsigned REGWIDTH   = 16,
  parameter int unsigned MAXLD      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [RADDRWIDTH-1:0]    alu_waddr,
  input  logic [REGWIDTH-1:0]      alu_wdata,
  input  logic                     ld_issue,
  input  logic [RADDRWIDTH-1:0]    ld_issue_waddr,
  output logic                     ld_issue_ready,
  input  logic                     ld_rvalid,
  input  logic [REGWIDTH-1:0]      ld_rdata,
  output logic                     we,
  output logic [RADDRWIDTH-1:0]    waddr,
  output logic [REGWIDTH-1:0]      wdata,
  output logic [2**RADDRWIDTH-1:0] busy,
  output logic                     err
);

  localparam int unsigned PW   = $clog2(MAXLD);
  localparam int unsigned CW   = $clog2(MAXLD + 1);
  localparam int unsigned NREG = 2**RADDRWIDTH;

  logic [RADDRWIDTH-1:0] tag_addr [MAXLD];
  logic [REGWIDTH-1:0]   tag_data [MAXLD];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  // Returns arrive in issue order, so returned entries are always the oldest nret.
  logic [CW-1:0]         nret;

  logic                  push_c;
  logic                  pop_c;
  logic                  rv_ok_c;
  logic                  commit_c;
  logic                  err_set_c;
  logic [PW-1:0]         ret_idx_c;
  logic [RADDRWIDTH-1:0] sel_addr_c;
  logic [REGWIDTH-1:0]   sel_data_c;

  always_comb begin
    ld_issue_ready = (count < CW'(MAXLD));
    push_c         = ld_issue & ld_issue_ready;
    rv_ok_c        = ld_rvalid & (nret < count);
    ret_idx_c      = head + PW'(nret);
    // Head is committable if already returned, or returning right now (bypass).
    pop_c          = ~alu_valid & ((nret != '0) | rv_ok_c);
    commit_c       = alu_valid | pop_c;
    sel_addr_c     = alu_valid ? alu_waddr : tag_addr[head];
    sel_data_c     = alu_valid ? alu_wdata
                   : ((nret != '0) ? tag_data[head] : ld_rdata);
    err_set_c      = (ld_issue & ~ld_issue_ready)
                   | (ld_rvalid & ~(nret < count))
                   | (alu_valid & (alu_waddr != '0) & busy[alu_waddr]);
  end

  // Scoreboard: OR of destinations over all occupied FIFO slots.
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < MAXLD; i++) begin
      if (CW'(i) < count) begin
        busy[tag_addr[head + PW'(i)]] = 1'b1;
      end
    end
    busy[0] = 1'b0;
  end

  // Tag FIFO payload storage; contents are don't-care when unoccupied.
  always_ff @(posedge clk) begin
    if (push_c) begin
      tag_addr[tail] <= ld_issue_waddr;
    end
    if (rv_ok_c) begin
      tag_data[ret_idx_c] <= ld_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      nret  <= '0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      err   <= 1'b0;
    end else begin
      head  <= head + PW'(pop_c);
      tail  <= tail + PW'(push_c);
      count <= count + CW'(push_c) - CW'(pop_c);
      nret  <= nret + CW'(rv_ok_c) - CW'(pop_c);
      err   <= err | err_set_c;
      // Commits to r0 retire normally but never reach the register file.
      we    <= commit_c & (sel_addr_c != '0);
      if (commit_c && (sel_addr_c != '0)) begin
        waddr <= sel_addr_c;
        wdata <= sel_data_c;
      end
    end
  end

  logic unused_c;
  assign unused_c = (NREG == 0);

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; sole driver of its single write port (we/waddr/wdata).
- Merges same-cycle ALU results with out-of-order-in-time (but in-issue-order) memory load returns.
- Tracks in-flight loads and exports a per-register busy scoreboard for the issue stage's stall logic.

Parameters:
RADDRWIDTH, 3, register address width; matches register file.
REGWIDTH, 16, register data width; matches register file.
MAXLD, 4, max outstanding loads (issued, not yet written back); power of two, >=2.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
alu_valid  in  1  ALU result valid this cycle; always accepted
alu_waddr  in  RADDRWIDTH  ALU destination register
alu_wdata  in  REGWIDTH  ALU result
ld_issue  in  1  load issued this cycle; honoured only when ld_issue_ready=1
ld_issue_waddr  in  RADDRWIDTH  load destination register
ld_issue_ready  out  1  outstanding count < MAXLD (combinational from state)
ld_rvalid  in  1  load data returning; returns in issue order
ld_rdata  in  REGWIDTH  returned load data
we  out  1  register file write enable (registered)
waddr  out  RADDRWIDTH  register file write address (registered)
wdata  out  REGWIDTH  register file write data (registered)
busy  out  2**RADDRWIDTH  bit i=1 while any outstanding load targets reg i; bit 0 always 0
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync release): we=0, waddr=0, wdata=0, err=0. Tag FIFO and data queue empty, outstanding=0, busy=0, ld_issue_ready=1.
- Tag FIFO (depth MAXLD): push {waddr, returned=0} on accepted ld_issue; ld_rvalid marks oldest unreturned entry returned and stores ld_rdata in it. Entries retire from head only.
- Commit selection each cycle, result registered to we/waddr/wdata next edge (1-cycle latency):
  1. alu_valid=1: commit ALU result (priority; ALU never stalls).
  2. Else if head entry returned: commit head load data, pop head.
  3. Else: we=0 next cycle; waddr/wdata hold previous values.
- Load return with no ALU and empty queue: ld_rvalid at cycle N -> we=1 at N+1 (same-cycle bypass into head).
- Destination reg 0: commit still happens (entry pops, slot retires) but we=0 for that cycle.
- outstanding = FIFO occupancy; accepted issue and head pop in same cycle -> count unchanged. ld_issue when ld_issue_ready=0: ignored, err<=1.
- busy[i] = OR over valid FIFO entries with waddr==i. Cleared the cycle after the commit that pops the entry, i.e. coincident with we=1 at the regfile. Two outstanding loads to same reg keep the bit set until both pop. Set the cycle after issue.
- err sets (sticky until reset) on:
  - ld_rvalid with no unreturned entry;
  - ld_issue when not ready;
  - alu_valid with alu_waddr!=0 and busy[alu_waddr]=1 (WAW hazard; issue stage must stall). The ALU write still commits.
- Load commits are strictly in issue order. A returned non-head entry waits behind an unreturned head (cannot occur given in-order returns).
- Reset mid-operation: all in-flight loads discarded, no write issued, busy cleared immediately.

Test Plan:
- ALU only: alu_valid, waddr=3, wdata=16'h1234 at cycle 5 -> we=1, waddr=3, wdata=16'h1234 at cycle 6; we=0 at cycle 7; busy=0 throughout.
- Single load: issue waddr=5 at cycle 2 -> busy[5]=1 from cycle 3. rvalid rdata=16'hBEEF at cycle 6 -> we/waddr=5/wdata=BEEF at cycle 7, busy[5]=0 at cycle 7.
- Collision: load return (waddr=2, 16'hAAAA) and ALU (waddr=4, 16'h5555) both at cycle 10 -> cycle 11 writes r4=5555, cycle 12 writes r2=AAAA.
- Capacity: issue 4 loads back-to-back -> ld_issue_ready=0 after the 4th. A 5th issue is ignored and sets err=1. Returning one load -> ready=1 the cycle after its commit.
- Reg 0 and duplicate target: loads to r0 then r6 then r6. Results:
  - r0 return -> no we, slot freed.
  - busy[6] stays 1 until the second r6 commit.
  - Writes appear in issue order.
- Violations/reset: rvalid with nothing outstanding -> err=1, no write. ALU to busy reg -> err=1, write still happens. Assert rst mid-burst with 3 outstanding -> busy=0, we=0, err=0, ld_issue_ready=1 immediately.
